mem_responder: RTL

- Memory-side responder for the fetch/memory-stage arbitration path.
- Accepts the single muxed request stream (address, read/write strobes, size select) and services it with a fixed multi-cycle latency.
- Returns read data and drives the shared delay/stall line, which the arbiter routes to whichever stage owns the access.
- Byte-addressable, little-endian unified instruction/data store.

---
 rtl/mem_responder_pkg.sv | 40 ++++
 rtl/mem_responder_mem_array.sv | 42 ++++
 rtl/mem_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and its neighbours.
//   - Size select encodings (also used by the arbiter and load/store units).
//   - Responder FSM state encoding.
//   - Lane helpers: byte-enable mask and misalignment test for a size/lane pair.
package mem_responder_pkg;

    localparam logic [1:0] SEL_BYTE  = 2'b00;
    localparam logic [1:0] SEL_HALF  = 2'b01;
    localparam logic [1:0] SEL_WORD  = 2'b10;
    localparam logic [1:0] SEL_FETCH = 2'b11;   // instruction fetch, behaves as a word

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Byte-enable mask for an aligned access of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] sel, input logic [1:0] lane);
        logic [3:0] mask;
        case (sel)
            SEL_BYTE: mask = 4'b0001 << lane;
            SEL_HALF: mask = 4'b0011 << lane;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Half accesses need an even address, word/fetch accesses a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] lane);
        logic mis;
        case (sel)
            SEL_BYTE: mis = 1'b0;
            SEL_HALF: mis = lane[0];
            default:  mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Synchronous single-port RAM, 2**DEPTH_LOG2 words of WIDTH bits.
// Ports:
//   clk_i    clock
//   addr_i   word index
//   we_i     write strobe, qualified per byte by be_i
//   be_i     byte enables (bit n covers wdata_i[8n+7:8n])
//   wdata_i  write data, already placed in its byte lanes
//   re_i     read strobe; rdata_o updates on the edge and then holds
//   rdata_o  registered read data
// The array is not reset.
module mem_responder_mem_array #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one muxed request at a time, stalls the
// requester for a fixed number of cycles, then performs the access.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   addr_i    byte address
//   we_i      write request (wins when re_i is also set)
//   re_i      read request
//   sel_i     size: byte / half / word / fetch (word)
//   wdata_i   store data, right-aligned
//   rdata_o   load data, right-aligned and zero-extended, valid in DONE, held after
//   mdelay_o  stall: high while a request is pending or in progress
//   err_o     one-cycle pulse in DONE for a misaligned access
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             mdelay_o,
    output logic             err_o
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam int AW = DEPTH_LOG2 + 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [AW-1:0]     req_addr_q;
    logic              req_we_q;
    logic [1:0]        req_sel_q;
    logic [WIDTH-1:0]  req_wdata_q;

    logic [WIDTH-1:0]  rdata_q;
    logic              err_q;

    logic              accept;
    logic              finish;
    logic              misaligned;
    logic [1:0]        lane;
    logic [DEPTH_LOG2-1:0] arr_addr;
    logic              arr_we;
    logic [3:0]        arr_be;
    logic [WIDTH-1:0]  arr_wdata;
    logic [WIDTH-1:0]  arr_rdata;
    logic [WIDTH-1:0]  rd_shift;
    logic [WIDTH-1:0]  rd_ext;

    // Address bits above the array are intentionally ignored (wraparound).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[WIDTH-1:AW];

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdelay_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (we_i || re_i) begin
                    mdelay_o = 1'b1;
                    state_d  = ST_BUSY;
                    cnt_d    = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                mdelay_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = (state_q == ST_IDLE) && (we_i || re_i);
    assign finish = (state_q == ST_BUSY) && (cnt_q == '0);

    // ---------------- request latch ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_sel_q   <= SEL_BYTE;
            req_wdata_q <= '0;
        end else if (accept) begin
            req_addr_q  <= addr_i[AW-1:0];
            req_we_q    <= we_i;
            req_sel_q   <= sel_i;
            req_wdata_q <= wdata_i;
        end
    end

    // ---------------- lane / alignment ----------------
    assign lane       = req_addr_q[1:0];
    assign misaligned = is_misaligned(req_sel_q, lane);
    assign arr_be     = lane_mask(req_sel_q, lane);
    assign arr_wdata  = req_wdata_q << {lane, 3'b000};
    assign arr_we     = finish && req_we_q && !misaligned;

    // The array read is launched on the accept edge so its registered output
    // is ready by the final BUSY cycle; only one access is ever in flight,
    // so nothing can write the word in between.
    assign arr_addr = (state_q == ST_IDLE) ? addr_i[AW-1:2] : req_addr_q[AW-1:2];

    mem_responder_mem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk_i   (clk_i),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .re_i    (accept),
        .rdata_o (arr_rdata)
    );

    // ---------------- extract / zero-extend ----------------
    always_comb begin
        rd_shift = arr_rdata >> {lane, 3'b000};
        case (req_sel_q)
            SEL_BYTE: rd_ext = WIDTH'(rd_shift[7:0]);
            SEL_HALF: rd_ext = WIDTH'(rd_shift[15:0]);
            default:  rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= finish && misaligned;
            if (finish) begin
                rdata_q <= (req_we_q || misaligned) ? '0 : rd_ext;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
